// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for pipe_ctrl: stall bit indices, FSM states, exception bit map and cause table.
// The optional performance counters are enabled with PIPE_CTRL_PERF_CNT_EN.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define ZeroWord  32'h0000_0000
`define Stop      1'b1
`define NoStop    1'b0
`define RstEnable 1'b0
`endif

package pipe_ctrl_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRAP_JUMP = 2'd1,
        ST_RET_JUMP  = 2'd2
    } state_t;

    // exception_i bit positions; bits above EXC_MRET have no cause entry
    localparam int EXC_INSTR_MISALIGN = 0;
    localparam int EXC_INSTR_FAULT    = 1;
    localparam int EXC_ILLEGAL        = 2;
    localparam int EXC_BREAKPOINT     = 3;
    localparam int EXC_LOAD_MISALIGN  = 4;
    localparam int EXC_LOAD_FAULT     = 5;
    localparam int EXC_STORE_MISALIGN = 6;
    localparam int EXC_STORE_FAULT    = 7;
    localparam int EXC_ECALL_M        = 8;
    localparam int EXC_MRET           = 9;
    localparam int EXC_TABLE_N        = 9;

    localparam logic [31:0] MRET_ONLY     = 32'h1 << EXC_MRET;
    // an exception with no table bit set reports illegal instruction
    localparam logic [31:0] CAUSE_DEFAULT = 32'd2;

    function automatic logic [31:0] cause_code(input int bit_idx);
        logic [31:0] code;
        case (bit_idx)
            EXC_INSTR_MISALIGN: code = 32'd0;
            EXC_INSTR_FAULT:    code = 32'd1;
            EXC_ILLEGAL:        code = 32'd2;
            EXC_BREAKPOINT:     code = 32'd3;
            EXC_LOAD_MISALIGN:  code = 32'd4;
            EXC_LOAD_FAULT:     code = 32'd5;
            EXC_STORE_MISALIGN: code = 32'd6;
            EXC_STORE_FAULT:    code = 32'd7;
            EXC_ECALL_M:        code = 32'd11;
            default:            code = CAUSE_DEFAULT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pipe_ctrl_exc_cause_enc.sv
// exc_cause_enc: combinational priority encoder from the exception vector to mcause.
// Lowest set table bit wins; the MRET bit never contributes a cause.
module exc_cause_enc
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] exception,
    output logic [31:0] cause
);

    always_comb begin
        cause = CAUSE_DEFAULT;
        for (int i = EXC_TABLE_N - 1; i >= 0; i--) begin
            if (exception[i]) begin
                cause = cause_code(i);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration, branch redirect forwarding and trap/mret sequencing.
// Define PIPE_CTRL_PERF_CNT_EN to add the stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             branch_redirect_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      exception_i,
    input  logic [31:0]      mem_pc_i,
    input  logic [31:0]      mtvec_i,
    input  logic [31:0]      mepc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             flush_front_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             trap_we_o,
    output logic [31:0]      trap_cause_o,
    output logic [31:0]      trap_epc_o,
    output logic             mret_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic [1:0]       state_o
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_ctrl: CNT_W must be at least 1");
    end

    state_t      state;
    state_t      state_next;
    logic [5:0]  stall_req_vec;
    logic [31:0] cause;
    logic        flush_event;

    exc_cause_enc u_cause_enc (
        .exception (exception_i),
        .cause     (cause)
    );

    // The deepest requesting stage freezes itself and everything upstream of it.
    always_comb begin
        if (stallreq_mem_i)     stall_req_vec = {`NoStop, {5{`Stop}}};
        else if (stallreq_ex_i) stall_req_vec = {{2{`NoStop}}, {4{`Stop}}};
        else if (stallreq_id_i) stall_req_vec = {{3{`NoStop}}, {3{`Stop}}};
        else if (stallreq_if_i) stall_req_vec = {{4{`NoStop}}, {2{`Stop}}};
        else                    stall_req_vec = {6{`NoStop}};
    end

    always_comb begin
        stall_o          = {6{`NoStop}};
        flush_o          = 1'b0;
        flush_front_o    = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = `ZeroWord;
        trap_we_o        = 1'b0;
        trap_cause_o     = `ZeroWord;
        trap_epc_o       = `ZeroWord;
        mret_o           = 1'b0;
        flush_event      = 1'b0;
        state_next       = ST_IDLE;
        // Outputs are held at zero while reset is asserted, even mid-sequence.
        if (n_rst_i != `RstEnable) begin
            case (state)
                ST_TRAP_JUMP: begin
                    flush_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = mtvec_i & 32'hFFFF_FFFC;
                end
                ST_RET_JUMP: begin
                    flush_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = mepc_i;
                end
                default: begin
                    if (exception_i != `ZeroWord) begin
                        flush_o     = 1'b1;
                        flush_event = 1'b1;
                        if (exception_i == MRET_ONLY) begin
                            mret_o     = 1'b1;
                            state_next = ST_RET_JUMP;
                        end else begin
                            trap_we_o    = 1'b1;
                            trap_cause_o = cause;
                            trap_epc_o   = mem_pc_i;
                            state_next   = ST_TRAP_JUMP;
                        end
                    end else begin
                        stall_o = stall_req_vec;
                        // A stalled EX stage will present the redirect again later.
                        if (branch_redirect_i && stall_req_vec[STALL_EX] == `NoStop) begin
                            flush_front_o    = 1'b1;
                            redirect_valid_o = 1'b1;
                            redirect_pc_o    = branch_target_i;
                            flush_event      = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (n_rst_i == `RstEnable) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign state_o = state;

`ifdef PIPE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (n_rst_i == `RstEnable) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_o != 6'd0) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_event)     flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed steps followed by randomized cycles against a behavioural model.
// Build with PIPE_CTRL_PERF_CNT_EN defined to also check the performance counters.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        sr_if, sr_id, sr_ex, sr_mem;
    logic        br;
    logic [31:0] br_target, exc, mem_pc, mtvec, mepc;
    logic [5:0]  stall;
    logic        flush, flush_front, rv, trap_we, mret;
    logic [31:0] rpc, cause, epc;
    logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [CNT_W-1:0] m_stall_cnt = '0, m_flush_cnt = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // model state: 0 = idle, 1 = trap jump pending, 2 = mret jump pending
    int          pending = 0;
    logic [5:0]  e_stall;
    logic        e_flush, e_front, e_rv, e_we, e_mret, e_event;
    logic [31:0] e_rpc, e_cause, e_epc;
    logic [1:0]  e_state;

    // mcause per exception bit 0..8, lowest set bit wins, default illegal instruction
    int cause_tab[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 11};
    localparam int BIT_ILLEGAL = 2;
    localparam int BIT_MRET    = 9;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i             (clk),
        .n_rst_i           (n_rst),
        .stallreq_if_i     (sr_if),
        .stallreq_id_i     (sr_id),
        .stallreq_ex_i     (sr_ex),
        .stallreq_mem_i    (sr_mem),
        .branch_redirect_i (br),
        .branch_target_i   (br_target),
        .exception_i       (exc),
        .mem_pc_i          (mem_pc),
        .mtvec_i           (mtvec),
        .mepc_i            (mepc),
        .stall_o           (stall),
        .flush_o           (flush),
        .flush_front_o     (flush_front),
        .redirect_valid_o  (rv),
        .redirect_pc_o     (rpc),
        .trap_we_o         (trap_we),
        .trap_cause_o      (cause),
        .trap_epc_o        (epc),
        .mret_o            (mret),
`ifdef PIPE_CTRL_PERF_CNT_EN
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt),
`endif
        .state_o           (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_cause(input logic [31:0] e);
        for (int b = 0; b < 9; b++) if (e[b]) return cause_tab[b];
        return 32'd2;
    endfunction

    task automatic model_outputs();
        int depth;
        e_stall = 0; e_flush = 0; e_front = 0; e_rv = 0; e_we = 0; e_mret = 0; e_event = 0;
        e_rpc = 0; e_cause = 0; e_epc = 0;
        e_state = (pending == 1) ? ST_TRAP_JUMP : (pending == 2) ? ST_RET_JUMP : ST_IDLE;
        if (n_rst !== 1'b1) return;
        if (pending == 1) begin
            e_flush = 1; e_rv = 1; e_rpc = (mtvec / 4) * 4;
        end else if (pending == 2) begin
            e_flush = 1; e_rv = 1; e_rpc = mepc;
        end else if (exc != 0) begin
            e_flush = 1; e_event = 1;
            if (exc == (32'h1 << BIT_MRET)) e_mret = 1;
            else begin e_we = 1; e_cause = model_cause(exc); e_epc = mem_pc; end
        end else begin
            // number of frozen stages counted from the pc end
            depth = sr_mem ? 5 : sr_ex ? 4 : sr_id ? 3 : sr_if ? 2 : 0;
            e_stall = 6'((1 << depth) - 1);
            if (br && depth < 4) begin
                e_front = 1; e_rv = 1; e_rpc = br_target; e_event = 1;
            end
        end
    endtask

    task automatic cycle();
        model_outputs();
        @(negedge clk);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("flush_front", 32'(flush_front), 32'(e_front));
        chk("redirect_valid", 32'(rv), 32'(e_rv));
        chk("redirect_pc", rpc, e_rpc);
        chk("trap_we", 32'(trap_we), 32'(e_we));
        chk("trap_cause", cause, e_cause);
        chk("trap_epc", epc, e_epc);
        chk("mret", 32'(mret), 32'(e_mret));
        chk("state", 32'(state), 32'(e_state));
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
`endif
        @(posedge clk);
        if (n_rst !== 1'b1) pending = 0;
        else if (pending != 0) pending = 0;
        else if (exc != 0) pending = (exc == (32'h1 << BIT_MRET)) ? 2 : 1;
`ifdef PIPE_CTRL_PERF_CNT_EN
        if (n_rst !== 1'b1) begin
            m_stall_cnt = '0; m_flush_cnt = '0;
        end else begin
            if (e_stall != 0) m_stall_cnt++;
            if (e_event) m_flush_cnt++;
        end
`endif
        #1;
    endtask

    task automatic clear_inputs();
        sr_if = 0; sr_id = 0; sr_ex = 0; sr_mem = 0; br = 0;
        br_target = 0; exc = 0; mem_pc = 0; mtvec = 0; mepc = 0;
    endtask

    initial begin
        n_rst = 0;
        clear_inputs();
        cycle(); cycle();
        n_rst = 1;
        cycle();

        // stall arbitration
        sr_ex = 1; sr_id = 1; cycle();
        chk("stall_ex_id", 32'(stall), 32'h0f);
        sr_mem = 1; cycle();
        sr_mem = 0; sr_ex = 0; sr_id = 0; sr_if = 1; cycle();
        sr_if = 0;

        // branch redirect, then one hidden behind an EX stall
        br = 1; br_target = 32'h0000_0120; cycle();
        sr_ex = 1; cycle();
        sr_ex = 0; sr_id = 1; cycle();
        br = 0; sr_id = 0;

        // illegal instruction trap
        exc = 32'h1 << BIT_ILLEGAL; mem_pc = 32'h40; mtvec = 32'h0000_0101; cycle();
        exc = 0; cycle();
        cycle();

        // mret
        exc = 32'h1 << BIT_MRET; mepc = 32'h44; cycle();
        exc = 0; cycle();

        // trap with concurrent branch and mem stall; inputs still active in TRAP_JUMP
        exc = 32'h0000_0120; br = 1; sr_mem = 1; mem_pc = 32'h88; cycle();
        cycle();
        exc = 0; br = 0; sr_mem = 0; cycle();

        // mret combined with another bit is a trap
        exc = (32'h1 << BIT_MRET) | 32'h8; cycle();
        exc = 0; cycle();

        // reset during TRAP_JUMP
        exc = 32'h1; sr_if = 1; cycle();
        exc = 0; n_rst = 0; cycle();
        cycle();
        n_rst = 1; cycle();
        sr_if = 0;

        for (int i = 0; i < 500; i++) begin
            n_rst     = ($urandom_range(0, 63) != 0);
            sr_if     = $urandom_range(0, 3) == 0;
            sr_id     = $urandom_range(0, 4) == 0;
            sr_ex     = $urandom_range(0, 5) == 0;
            sr_mem    = $urandom_range(0, 6) == 0;
            br        = $urandom_range(0, 2) == 0;
            br_target = $urandom;
            mem_pc    = $urandom;
            mtvec     = $urandom;
            mepc      = $urandom;
            case ($urandom_range(0, 11))
                0:       exc = 32'h1 << BIT_MRET;
                1:       exc = $urandom;
                2, 3:    exc = 32'($urandom_range(1, 1023));
                default: exc = 0;
            endcase
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit and the producing end of the stall/flush interface consumed by every stage register (pc, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates stage stall requests into a 6-bit stall vector.
- Sequences trap entry and mret return through a small FSM: flush the pipeline, write trap CSRs, redirect fetch.
- Also forwards EX-stage branch mispredict redirects.

Parameters:
- CNT_W, 32, width of the optional stall/flush performance counters.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  synchronous reset, active-low (`RstEnable = 0)
- stallreq_if_i / stallreq_id_i / stallreq_ex_i / stallreq_mem_i  in  1 each  stage stall requests
- branch_redirect_i  in  1  EX mispredict
- branch_target_i  in  32  corrected PC
- exception_i  in  32  MEM-stage exception vector (pkg bit map); nonzero = trap/mret
- mem_pc_i  in  32  PC of the MEM-stage instruction
- mtvec_i, mepc_i  in  32  CSR values
- stall_o  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb
- flush_o  out  1  clear all stage registers
- flush_front_o  out  1  clear if_id and id_ex only
- redirect_valid_o  out  1  load PC from redirect_pc_o
- redirect_pc_o  out  32  new fetch PC
- trap_we_o  out  1  write mepc/mcause, update mstatus
- trap_cause_o  out  32  mcause value
- trap_epc_o  out  32  mepc value
- mret_o  out  1  restore mstatus

Behaviour:
- Consumer contract: stage k inserts a bubble when stall[k]=1 and stall[k+1]=0; it holds when both are 1.
- Stall priority, combinational: mem → 6'b011111; else ex → 6'b001111; else id → 6'b000111; else if → 6'b000011; else 0.
- FSM states: IDLE, TRAP_JUMP, RET_JUMP. Reset puts the FSM in IDLE and forces all outputs to 0.
- IDLE with exception_i == 0:
  - Outputs are the stall vector above.
  - If branch_redirect_i: flush_front_o=1, redirect_valid_o=1, redirect_pc_o=branch_target_i, all in the same cycle.
  - A branch redirect during a stall in which stall_o[3]=1 is ignored; EX re-presents it.
- IDLE with exception_i != 0 and the mret bit clear, cycle N (Mealy):
  - flush_o=1, stall_o=0, trap_we_o=1.
  - trap_cause_o = priority-encoded cause (lowest set bit wins; pkg table).
  - trap_epc_o = mem_pc_i.
  - Next state TRAP_JUMP.
- TRAP_JUMP, cycle N+1 (Moore):
  - flush_o=1, redirect_valid_o=1, redirect_pc_o = {mtvec_i[31:2],2'b00}.
  - Next state IDLE.
- IDLE with exception_i == MRET-only bit, cycle N:
  - flush_o=1, mret_o=1, no trap_we_o.
  - Next state RET_JUMP.
- RET_JUMP, cycle N+1: flush_o=1, redirect_valid_o=1, redirect_pc_o=mepc_i; next state IDLE.
- Simultaneous events:
  - A trap/mret overrides stall requests and branch_redirect_i in the same cycle.
  - mret together with any other exception bit is treated as a trap.
- In TRAP_JUMP/RET_JUMP:
  - exception_i and branch_redirect_i are ignored.
  - stall_o=0 regardless of requests, because the pipeline is already flushed.
- Reset asserted mid-sequence returns the FSM to IDLE with no redirect issued.
- Trap latency: exception seen at N; the stage-register clear happens at the edge ending N; fetch resumes at the handler PC in N+2.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt_o[CNT_W-1:0] and flush_cnt_o[CNT_W-1:0].
  - stall_cnt_o increments each cycle stall_o != 0.
  - flush_cnt_o increments once per trap/mret/branch event.
  - Both wrap modulo 2^CNT_W and are cleared by reset.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines:
  - stall bit indices, FSM state encodings, exception_i bit positions (including the MRET bit);
  - the cause-code table, using existing `ZeroWord`, `Stop`, `NoStop`, `RstEnable`.
- One natural sub-module: exc_cause_enc, a combinational priority encoder from exception_i to the 32-bit mcause.

Test Plan:
- stallreq_ex_i=1 with stallreq_id_i=1 → stall_o=6'b001111; then stallreq_mem_i=1 → 6'b011111, no flush.
- branch_redirect_i=1, branch_target_i=32'h0000_0120 → same cycle: flush_front_o=1, redirect_valid_o=1, redirect_pc_o=32'h120; flush_o=0.
- Illegal-instruction bit set, mem_pc_i=32'h0000_0040, mtvec_i=32'h0000_0101:
  - cycle N: flush_o=1, trap_we_o=1, trap_epc_o=32'h40, cause=2;
  - cycle N+1: redirect_pc_o=32'h100.
- MRET bit only, mepc_i=32'h0000_0044 → N: mret_o=1, flush_o=1, trap_we_o=0; N+1: redirect_pc_o=32'h44.
- Exception concurrent with branch_redirect_i and stallreq_mem_i → trap sequence only, stall_o=0, no branch redirect.
- n_rst_i=0 during TRAP_JUMP → next cycle all outputs 0, state IDLE; with PIPE_CTRL_PERF_CNT_EN, counters read 0.
